lap_record_scheduler: RTL and testbench
=======================================

# lap_record_scheduler

Sequences lap-record and clear requests onto the single LCD record channel (the `lcd_bridge` insert/clear/busy interface), which can only take one operation at a time. Lap snapshots from the key FSM are captured into a small FIFO while the LCD is busy and replayed one at a time. Clear requests take priority and flush any queued laps. The block sits between the key FSM / timer BCD snapshot and `lcd_bridge`.

## Interface
- RECORD_W, 32, width of one flattened BCD lap record (4 units × 2 digits × 4 bits)
- DEPTH, 4, FIFO entries; must be a power of 2, ≥ 2
- ACK_TIMEOUT, 16, cycles to wait for `lcd_busy` to rise after an issued command before treating the command as complete
- clock  in  1  system clock (50 MHz)
- reset  in  1  asynchronous, active-high; all state cleared
- lap_req  in  1  single-cycle request to record `lap_record`
- lap_record  in  RECORD_W  BCD snapshot, sampled on the edge where `lap_req` is high
- clear_req  in  1  single-cycle request to clear the LCD lap list
- lcd_busy  in  1  busy flag from the LCD bridge
- insert  out  1  one-cycle insert strobe to the LCD bridge
- new_record  out  RECORD_W  record being issued; held stable from `insert` until the operation completes
- clear  out  1  one-cycle clear strobe to the LCD bridge
- pending  out  clog2(DEPTH)+1  number of queued laps, not counting the one in flight
- overflow  out  1  sticky; set when a lap is dropped because the FIFO is full
- busy  out  1  high whenever state ≠ IDLE, pending ≠ 0, or a clear is latched

## Operation
- The FIFO holds DEPTH records. On `lap_req`, the record is written if the FIFO is not full. A write when full is dropped and sets `overflow`, except when a pop happens in the same cycle; then the write is accepted.
- On `clear_req`:
  - the FIFO is flushed immediately (`pending` → 0);
  - `overflow` is cleared;
  - `clear_pend` is latched.
- If `lap_req` and `clear_req` arrive in the same cycle, clear wins and the lap is discarded.
- The FSM has four states: IDLE, ISSUE, WAIT_ACK, WAIT_DONE.
  - IDLE → ISSUE when `lcd_busy` = 0 and either `clear_pend` = 1 or the FIFO is non-empty. Clear has priority over a lap.
    - For a clear: `clear_pend` is cleared and the operation type is recorded as clear.
    - For a lap: the head entry is popped into the `new_record` register and the operation type is recorded as insert.
  - ISSUE: `insert` or `clear` (per the operation type) is high for exactly this one cycle. Next state is WAIT_ACK and the timeout counter is loaded with 0.
  - WAIT_ACK → WAIT_DONE when `lcd_busy` = 1. WAIT_ACK → IDLE when the counter reaches ACK_TIMEOUT−1 with `lcd_busy` still 0. Otherwise the counter increments.
  - WAIT_DONE → IDLE when `lcd_busy` = 0.
- A `clear_req` that arrives during ISSUE, WAIT_ACK or WAIT_DONE does not abort the operation in flight. It flushes the FIFO and is issued after the current operation returns to IDLE.
- `new_record` changes only on a pop. It is never altered by a clear.
- Reset mid-operation returns the block to IDLE at once:
  - FIFO emptied;
  - `clear_pend` and `overflow` cleared;
  - no strobe is emitted after reset deasserts until a new request arrives.

## Timing
- Reset values:
  - `insert` = 0, `clear` = 0, `new_record` = 0;
  - `pending` = 0, `overflow` = 0, `busy` = 0;
  - FSM in IDLE; FIFO pointers = 0.
- All outputs are registered.
- Lap latency:
  - Conditions: `lap_req` sampled at edge N, FSM in IDLE, `lcd_busy` = 0.
  - Edge N: FIFO write.
  - Edge N+1: pop, go to ISSUE.
  - `insert` is high in the cycle after edge N+1 (2-cycle latency).
- Clear latency: `clear_req` at edge N in IDLE → `clear` high in the cycle after edge N+1.
- Back-to-back operations: at least 1 IDLE cycle separates successive strobes. The minimum spacing is 4 cycles plus the bridge's busy time.
- The `pending` update is visible the cycle after the write, pop or flush edge.
- ACK timeout: `lcd_busy` never rising after a strobe gives exactly ACK_TIMEOUT WAIT_ACK cycles, then IDLE.

## Test plan
- Single lap, idle bridge:
  - Stimulus: `lap_req` with `lap_record` = 32'h0012_3456; bridge model raises busy 1 cycle after `insert` and holds it 50 cycles.
  - Required: `insert` pulse 2 cycles later; `new_record` = 32'h0012_3456 stable until busy falls; `busy` falls 2 cycles after `lcd_busy` falls.
- Burst past capacity (DEPTH = 4):
  - Stimulus: 6 laps (records 1–6) on consecutive cycles while `lcd_busy` is held high.
  - Required: records 1–4 are queued (`pending` = 4); records 5 and 6 are dropped and `overflow` = 1; after busy releases, 4 inserts are issued in order 1, 2, 3, 4.
- Clear during in-flight insert:
  - Stimulus: 3 laps queued; `clear_req` during WAIT_DONE of lap 1.
  - Required: `pending` → 0 next cycle; `overflow` → 0; after lap 1 completes, exactly one `clear` pulse; no further inserts.
- Simultaneous requests:
  - Stimulus: `lap_req` and `clear_req` on the same edge in IDLE.
  - Required: one `clear` pulse; zero `insert` pulses; `pending` stays 0.
- ACK timeout:
  - Stimulus: bridge model ignores strobes (`lcd_busy` tied 0); 2 laps.
  - Required: inserts spaced exactly ACK_TIMEOUT + 3 cycles apart; both records are presented in order.
- Async reset:
  - Stimulus: assert `reset` mid-WAIT_DONE with 2 laps queued, then release.
  - Required: all outputs at reset values immediately, without waiting for a clock edge; no strobe until a new request arrives.

Source files
------------

// File: rtl/lap_record_scheduler_if.sv
// Lap-record scheduler bus: key FSM / BCD snapshot side and LCD bridge side.
// The master drives requests and the bridge busy flag, the slave drives strobes.
interface lap_record_scheduler_if #(
    parameter int RECORD_W = 32,
    parameter int DEPTH    = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic                lap_req;
    logic [RECORD_W-1:0] lap_record;
    logic                clear_req;
    logic                lcd_busy;
    logic                insert;
    logic [RECORD_W-1:0] new_record;
    logic                clear;
    logic [CW-1:0]       pending;
    logic                overflow;
    logic                busy;

    modport master (
        output lap_req, lap_record, clear_req, lcd_busy,
        input  insert, new_record, clear, pending, overflow, busy
    );

    modport slave (
        input  lap_req, lap_record, clear_req, lcd_busy,
        output insert, new_record, clear, pending, overflow, busy
    );
endinterface

// File: rtl/lap_record_scheduler.sv
// Serialises lap inserts and list clears onto the single LCD record channel.
// Laps wait in a small FIFO; clears flush it and win over queued laps.
module lap_record_scheduler #(
    parameter int RECORD_W    = 32,
    parameter int DEPTH       = 4,
    parameter int ACK_TIMEOUT = 16
) (
    input  logic clock,
    input  logic reset,
    lap_record_scheduler_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(ACK_TIMEOUT) + 1;

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] ISSUE     = 2'd1;
    localparam logic [1:0] WAIT_ACK  = 2'd2;
    localparam logic [1:0] WAIT_DONE = 2'd3;

    logic [RECORD_W-1:0] mem [DEPTH];
    logic [AW-1:0]       wr_ptr;
    logic [AW-1:0]       rd_ptr;
    logic [CW-1:0]       count;
    logic [1:0]          state;
    logic                clear_pend;
    logic                guard;
    logic [TW-1:0]       timer;
    logic [RECORD_W-1:0] record_q;
    logic                insert_q;
    logic                clear_q;
    logic                overflow_q;
    logic                busy_q;

    logic empty;
    logic full;
    logic launch_clear;
    logic launch_lap;
    logic do_write;
    logic do_drop;

    // Launch decisions and FIFO write/drop qualification
    always_comb begin
        empty        = (count == '0);
        full         = (count == CW'(DEPTH));
        launch_clear = (state == IDLE) && !guard && !bus.lcd_busy
                       && clear_pend;
        launch_lap   = (state == IDLE) && !guard && !bus.lcd_busy
                       && !clear_pend && !empty && !bus.clear_req;
        do_write     = bus.lap_req && !bus.clear_req
                       && (!full || launch_lap);
        do_drop      = bus.lap_req && !bus.clear_req
                       && full && !launch_lap;
    end

    // FIFO storage; contents need no reset since count gates every read
    always_ff @(posedge clock) begin
        if (do_write) begin
            mem[wr_ptr] <= bus.lap_record;
        end
    end

    // FIFO pointers and occupancy; a clear request flushes everything
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (bus.clear_req) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_write) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (launch_lap) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + CW'(do_write) - CW'(launch_lap);
        end
    end

    // Channel FSM: one operation in flight, strobe for one cycle,
    // then wait for the bridge to acknowledge or time out; one settle
    // cycle (guard) follows every completed operation
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            clear_pend <= 1'b0;
            guard      <= 1'b0;
            timer      <= '0;
            record_q   <= '0;
            insert_q   <= 1'b0;
            clear_q    <= 1'b0;
        end else begin
            insert_q <= 1'b0;
            clear_q  <= 1'b0;
            guard    <= 1'b0;
            if (bus.clear_req) begin
                clear_pend <= 1'b1;
            end else if (launch_clear) begin
                clear_pend <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (launch_clear) begin
                        clear_q <= 1'b1;
                        state   <= ISSUE;
                    end else if (launch_lap) begin
                        record_q <= mem[rd_ptr];
                        insert_q <= 1'b1;
                        state    <= ISSUE;
                    end
                end
                ISSUE: begin
                    timer <= '0;
                    state <= WAIT_ACK;
                end
                WAIT_ACK: begin
                    if (bus.lcd_busy) begin
                        state <= WAIT_DONE;
                    end else if (timer == TW'(ACK_TIMEOUT - 1)) begin
                        state <= IDLE;
                        guard <= 1'b1;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                WAIT_DONE: begin
                    if (!bus.lcd_busy) begin
                        state <= IDLE;
                        guard <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Sticky overflow and registered activity flag
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            overflow_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            if (bus.clear_req) begin
                overflow_q <= 1'b0;
            end else if (do_drop) begin
                overflow_q <= 1'b1;
            end
            busy_q <= (state != IDLE) || (count != '0) || clear_pend;
        end
    end

    assign bus.insert     = insert_q;
    assign bus.clear      = clear_q;
    assign bus.new_record = record_q;
    assign bus.pending    = count;
    assign bus.overflow   = overflow_q;
    assign bus.busy       = busy_q;
endmodule

// File: tb/tb_lap_record_scheduler.sv
// Scoreboard bench for lap_record_scheduler with a simple LCD bridge model.
// Expected strobes are queued by stimulus and checked by a separate monitor.
module tb_lap_record_scheduler;
    typedef struct {
        bit          is_clear;
        logic [31:0] rec;
    } exp_t;

    logic clock;
    logic reset;
    logic bridge_busy;
    logic ext_busy;
    bit   bridge_on;
    int   bridge_hold;
    int   cyc;
    int   n_cmp;
    int   n_bad;
    exp_t exp_q[$];
    exp_t mon_e;
    int   strobe_cyc[$];

    lap_record_scheduler_if #(.RECORD_W(32), .DEPTH(4)) bus();

    assign bus.lcd_busy = bridge_busy | ext_busy;

    lap_record_scheduler #(
        .RECORD_W(32),
        .DEPTH(4),
        .ACK_TIMEOUT(16)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] got,
                         input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     name, got, exp, cyc);
        end
    endtask

    task automatic tick();
        @(negedge clock);
        #1;
    endtask

    task automatic push_exp(input bit is_clear, input logic [31:0] rec);
        exp_t e;
        e.is_clear = is_clear;
        e.rec      = rec;
        exp_q.push_back(e);
    endtask

    task automatic send_laps(input int n, input logic [31:0] base,
                             output int first_cyc);
        first_cyc = 0;
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
            if (i == 0) first_cyc = cyc;
            bus.lap_req    = 1'b1;
            bus.lap_record = base + 32'(i);
        end
        @(posedge clock);
        #1;
        bus.lap_req = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || bus.busy || bus.lcd_busy)
               && n < budget) begin
            tick();
            n++;
        end
        check(name, 64'(n < budget), 64'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_insert"}, 64'(bus.insert), 64'd0);
        check({tag, "_clear"}, 64'(bus.clear), 64'd0);
        check({tag, "_new_record"}, 64'(bus.new_record), 64'd0);
        check({tag, "_pending"}, 64'(bus.pending), 64'd0);
        check({tag, "_overflow"}, 64'(bus.overflow), 64'd0);
        check({tag, "_busy"}, 64'(bus.busy), 64'd0);
    endtask

    // Bridge model: raise busy the cycle after a strobe, hold it
    initial begin
        bridge_busy = 1'b0;
        forever begin
            @(negedge clock);
            if (bridge_on && !reset && (bus.insert || bus.clear)) begin
                @(posedge clock);
                #1 bridge_busy = 1'b1;
                repeat (bridge_hold) @(posedge clock);
                #1 bridge_busy = 1'b0;
            end
        end
    end

    // Monitor: every strobe must match the head of the expected queue
    always @(negedge clock) begin
        if (!reset && (bus.insert || bus.clear)) begin
            strobe_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
                check("unexpected_strobe",
                      64'({bus.clear, bus.insert}), 64'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("strobe",
                      64'({bus.clear,
                           bus.insert ? bus.new_record : 32'h0}),
                      64'({mon_e.is_clear, mon_e.rec}));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        int n;
        int bad;
        int d;
        n_cmp = 0;
        n_bad = 0;
        reset = 1'b1;
        ext_busy = 1'b0;
        bridge_on = 1'b1;
        bridge_hold = 50;
        bus.lap_req = 1'b0;
        bus.lap_record = '0;
        bus.clear_req = 1'b0;

        repeat (3) tick();
        check_reset_outputs("rst0");
        @(posedge clock);
        #2 reset = 1'b0;
        tick();
        check_reset_outputs("post_rst");

        // Single lap with idle bridge
        strobe_cyc.delete();
        push_exp(1'b0, 32'h0012_3456);
        send_laps(1, 32'h0012_3456, t0);
        n = 0;
        while (strobe_cyc.size() == 0 && n < 20) begin tick(); n++; end
        d = (strobe_cyc.size() > 0) ? strobe_cyc[0] - t0 : -1;
        check("t1_insert_latency", 64'(d), 64'd2);
        n = 0;
        while (!bus.lcd_busy && n < 20) begin tick(); n++; end
        check("t1_lcd_busy_rise", 64'(n < 20), 64'd1);
        bad = 0;
        n = 0;
        while (bus.lcd_busy && n < 100) begin
            if (bus.new_record !== 32'h0012_3456) bad++;
            tick();
            n++;
        end
        check("t1_record_stable", 64'(bad), 64'd0);
        check("t1_lcd_busy_fall", 64'(n < 100), 64'd1);
        tick();
        check("t1_busy_fall_plus1", 64'(bus.busy), 64'd1);
        tick();
        check("t1_busy_fall_plus2", 64'(bus.busy), 64'd0);
        wait_idle("t1_done", 100);
        repeat (20) tick();

        // Burst past FIFO capacity while bridge is busy
        strobe_cyc.delete();
        bridge_hold = 3;
        @(posedge clock);
        #1 ext_busy = 1'b1;
        send_laps(6, 32'd1, t0);
        tick();
        check("t2_pending_full", 64'(bus.pending), 64'd4);
        check("t2_overflow_set", 64'(bus.overflow), 64'd1);
        for (int i = 1; i <= 4; i++) push_exp(1'b0, 32'(i));
        @(posedge clock);
        #1 ext_busy = 1'b0;
        wait_idle("t2_done", 300);
        check("t2_insert_count", 64'(strobe_cyc.size()), 64'd4);
        d = (strobe_cyc.size() >= 4) ? strobe_cyc[3] - strobe_cyc[0] : -1;
        check("t2_spacing", 64'(d), 64'd21);
        check("t2_pending_empty", 64'(bus.pending), 64'd0);
        check("t2_overflow_sticky", 64'(bus.overflow), 64'd1);
        repeat (20) tick();

        // Clear while lap 1 is in WAIT_DONE, two laps still queued
        strobe_cyc.delete();
        bridge_hold = 10;
        push_exp(1'b0, 32'h0000_00A0);
        send_laps(3, 32'h0000_00A0, t0);
        n = 0;
        while (!bus.lcd_busy && n < 20) begin tick(); n++; end
        tick();
        check("t3_pending_before", 64'(bus.pending), 64'd2);
        check("t3_overflow_before", 64'(bus.overflow), 64'd1);
        push_exp(1'b1, 32'h0);
        @(posedge clock);
        #1 bus.clear_req = 1'b1;
        @(posedge clock);
        #1 bus.clear_req = 1'b0;
        tick();
        check("t3_pending_flushed", 64'(bus.pending), 64'd0);
        check("t3_overflow_cleared", 64'(bus.overflow), 64'd0);
        wait_idle("t3_done", 200);
        repeat (30) tick();
        check("t3_strobe_count", 64'(strobe_cyc.size()), 64'd2);

        // Simultaneous lap and clear in IDLE
        strobe_cyc.delete();
        bridge_hold = 3;
        push_exp(1'b1, 32'h0);
        @(posedge clock);
        #1;
        bus.clear_req = 1'b1;
        bus.lap_req = 1'b1;
        bus.lap_record = 32'h0000_BEEF;
        @(posedge clock);
        #1;
        bus.clear_req = 1'b0;
        bus.lap_req = 1'b0;
        tick();
        check("t4_pending_zero", 64'(bus.pending), 64'd0);
        wait_idle("t4_done", 100);
        repeat (30) tick();
        check("t4_strobe_count", 64'(strobe_cyc.size()), 64'd1);

        // ACK timeout: bridge ignores strobes
        strobe_cyc.delete();
        bridge_on = 1'b0;
        push_exp(1'b0, 32'h0000_5500);
        push_exp(1'b0, 32'h0000_5501);
        send_laps(2, 32'h0000_5500, t0);
        wait_idle("t5_done", 200);
        d = (strobe_cyc.size() >= 1) ? strobe_cyc[0] - t0 : -1;
        check("t5_first_latency", 64'(d), 64'd2);
        d = (strobe_cyc.size() >= 2) ? strobe_cyc[1] - strobe_cyc[0] : -1;
        check("t5_timeout_spacing", 64'(d), 64'd19);
        repeat (10) tick();

        // Async reset mid-WAIT_DONE with two laps queued
        strobe_cyc.delete();
        bridge_on = 1'b1;
        bridge_hold = 20;
        push_exp(1'b0, 32'h0000_0C00);
        send_laps(3, 32'h0000_0C00, t0);
        n = 0;
        while (!bus.lcd_busy && n < 20) begin tick(); n++; end
        tick();
        check("t6_pending_before", 64'(bus.pending), 64'd2);
        check("t6_busy_before", 64'(bus.busy), 64'd1);
        @(posedge clock);
        #2 reset = 1'b1;
        #1;
        check_reset_outputs("t6_async");
        repeat (2) @(posedge clock);
        #2 reset = 1'b0;
        repeat (40) tick();
        check("t6_no_strobe", 64'(strobe_cyc.size()), 64'd1);
        check_reset_outputs("t6_after");
        push_exp(1'b0, 32'h0000_0D0D);
        send_laps(1, 32'h0000_0D0D, t0);
        wait_idle("t6_done", 200);
        check("t6_new_strobe", 64'(strobe_cyc.size()), 64'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end
endmodule
